// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for one modulo up/down counter.
// The master side drives the count controls. The slave side (the counter) returns
// the binary and BCD counts and the single-cycle event pulses.
interface mod_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up;
    logic             down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic [7:0]       cnt_bcd;
    logic             carry;
    logic             borrow;
    logic             conflict;
    logic             load_err;

    modport master (
        output en, up, down, load, load_val,
        input  cnt, cnt_bcd, carry, borrow, conflict, load_err
    );

    modport slave (
        input  en, up, down, load, load_val,
        output cnt, cnt_bcd, carry, borrow, conflict, load_err
    );
endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised modulo [MIN, MAX] up/down counter used in the time-setting datapath.
// Carry and borrow pulse on a wrap so that instances can be cascaded.
// A load is range-checked. Asking to count up and down together raises conflict.
// cnt_bcd is a registered copy of the count in two BCD digits and lags cnt by one cycle.
module mod_updown_counter #(
    parameter int WIDTH = 8,
    parameter int MIN   = 0,
    parameter int MAX   = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    mod_updown_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
    localparam logic [7:0]       MIN_BCD = 8'((((MIN / 10) % 10) << 4) | (MIN % 10));

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cnt_next;
    logic [7:0]       r_cnt_bcd;
    logic             r_carry,    r_carry_next;
    logic             r_borrow,   r_borrow_next;
    logic             r_conflict, r_conflict_next;
    logic             r_load_err, r_load_err_next;

    logic             w_cnt_below, w_cnt_above;
    logic             w_lv_below,  w_lv_above;
    logic             w_cnt_in_range;
    logic             w_load_ok;

    // A bound at the edge of the WIDTH-bit range can never be exceeded.
    // Those compares are left out so that no constant-result comparison is built.
    generate
        if (MIN == 0) begin : g_no_low
            assign w_cnt_below = 1'b0;
            assign w_lv_below  = 1'b0;
        end else begin : g_low
            assign w_cnt_below = (r_cnt < MIN_V);
            assign w_lv_below  = (bus.load_val < MIN_V);
        end
        if (MAX >= (2 ** WIDTH) - 1) begin : g_no_high
            assign w_cnt_above = 1'b0;
            assign w_lv_above  = 1'b0;
        end else begin : g_high
            assign w_cnt_above = (r_cnt > MAX_V);
            assign w_lv_above  = (bus.load_val > MAX_V);
        end
    endgenerate

    assign w_cnt_in_range = !w_cnt_below && !w_cnt_above;
    assign w_load_ok      = !w_lv_below && !w_lv_above;

    // Binary to BCD conversion by a compare chain against 10, 20, ..., 90.
    // Counts above 99 have no meaningful BCD value.
    logic [31:0] w_cnt_ext;
    logic [8:0]  w_tens_ge;
    logic [3:0]  w_tens;
    logic [3:0]  w_ones;

    assign w_cnt_ext = 32'(r_cnt);

    genvar gi;
    generate
        for (gi = 1; gi <= 9; gi++) begin : g_tens_cmp
            assign w_tens_ge[gi-1] = (w_cnt_ext >= 32'(gi * 10));
        end
    endgenerate

    // Select the highest decade the count has reached. The ones digit is the remainder.
    always_comb begin
        w_tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (w_tens_ge[i]) w_tens = 4'(i + 1);
        end
        w_ones = 4'(w_cnt_ext - (32'(w_tens) * 32'd10));
    end

    // Next count and pulses. Load has priority over count, and count has priority over hold.
    always_comb begin
        r_cnt_next      = r_cnt;
        r_carry_next    = 1'b0;
        r_borrow_next   = 1'b0;
        r_conflict_next = 1'b0;
        r_load_err_next = 1'b0;
        if (bus.load) begin
            if (w_load_ok) r_cnt_next      = bus.load_val;
            else           r_load_err_next = 1'b1;
        end else if (bus.en) begin
            if (bus.up && bus.down) begin
                r_conflict_next = 1'b1;
            end else if (bus.up || bus.down) begin
                if (!w_cnt_in_range) begin
                    // An upset count is recovered to MIN without signalling a wrap.
                    r_cnt_next = MIN_V;
                end else if (bus.up) begin
                    if (r_cnt == MAX_V) begin
                        r_cnt_next   = MIN_V;
                        r_carry_next = 1'b1;
                    end else begin
                        r_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    if (r_cnt == MIN_V) begin
                        r_cnt_next    = MAX_V;
                        r_borrow_next = 1'b1;
                    end else begin
                        r_cnt_next = r_cnt - 1'b1;
                    end
                end
            end
        end
    end

    // Register the count, BCD and pulses. Reset sets cnt and cnt_bcd together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= MIN_V;
            r_cnt_bcd  <= MIN_BCD;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_conflict <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_cnt      <= r_cnt_next;
            r_cnt_bcd  <= {w_tens, w_ones};
            r_carry    <= r_carry_next;
            r_borrow   <= r_borrow_next;
            r_conflict <= r_conflict_next;
            r_load_err <= r_load_err_next;
        end
    end

    assign bus.cnt      = r_cnt;
    assign bus.cnt_bcd  = r_cnt_bcd;
    assign bus.carry    = r_carry;
    assign bus.borrow   = r_borrow;
    assign bus.conflict = r_conflict;
    assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter.
// It uses an hours instance (0-23), a day-of-month instance (1-31) and a cascaded
// seconds->minutes pair (0-59).
module tb_mod_updown_counter;
    logic clk = 1'b0;
    logic rst_h = 1'b1, rst_d = 1'b1, rst_c = 1'b1;
    always #5 clk = ~clk;

    mod_updown_counter_if #(.WIDTH(8)) h_if ();
    mod_updown_counter_if #(.WIDTH(8)) d_if ();
    mod_updown_counter_if #(.WIDTH(8)) s_if ();
    mod_updown_counter_if #(.WIDTH(8)) m_if ();

    mod_updown_counter #(.WIDTH(8), .MIN(0), .MAX(23)) u_hr  (.clk(clk), .rst(rst_h), .bus(h_if.slave));
    mod_updown_counter #(.WIDTH(8), .MIN(1), .MAX(31)) u_day (.clk(clk), .rst(rst_d), .bus(d_if.slave));
    mod_updown_counter #(.WIDTH(8), .MIN(0), .MAX(59)) u_sec (.clk(clk), .rst(rst_c), .bus(s_if.slave));
    mod_updown_counter #(.WIDTH(8), .MIN(0), .MAX(59)) u_min (.clk(clk), .rst(rst_c), .bus(m_if.slave));

    // Minutes advance on the seconds carry in the up direction.
    assign m_if.en   = s_if.carry;
    assign m_if.up   = 1'b1;
    assign m_if.down = 1'b0;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int cnt;
        int bcd;
        bit carry;
        bit borrow;
        bit conflict;
        bit load_err;
    } ms_t;

    function automatic int to_bcd(input int v);
        return ((v / 10) * 16) + (v % 10);
    endfunction

    function automatic ms_t step(input ms_t s, input int mn, input int mx, input bit r,
                                 input bit en, input bit up, input bit dn,
                                 input bit ld, input int lv);
        ms_t n;
        n = s;
        n.carry = 0; n.borrow = 0; n.conflict = 0; n.load_err = 0;
        n.bcd = to_bcd(s.cnt);
        if (r) begin
            n.cnt = mn;
            n.bcd = to_bcd(mn);
        end else if (ld) begin
            if (lv >= mn && lv <= mx) n.cnt = lv;
            else                      n.load_err = 1;
        end else if (en) begin
            if (up && dn) n.conflict = 1;
            else if (up || dn) begin
                if (s.cnt < mn || s.cnt > mx) n.cnt = mn;
                else if (up) begin
                    if (s.cnt == mx) begin n.cnt = mn; n.carry = 1; end
                    else n.cnt = s.cnt + 1;
                end else begin
                    if (s.cnt == mn) begin n.cnt = mx; n.borrow = 1; end
                    else n.cnt = s.cnt - 1;
                end
            end
        end
        return n;
    endfunction

    ms_t mh, md, msc, mmn;

    always @(posedge clk) begin
        bit sec_carry_old;
        sec_carry_old = msc.carry;
        mh  = step(mh,  0, 23, rst_h, h_if.en, h_if.up, h_if.down, h_if.load, int'(h_if.load_val));
        md  = step(md,  1, 31, rst_d, d_if.en, d_if.up, d_if.down, d_if.load, int'(d_if.load_val));
        msc = step(msc, 0, 59, rst_c, s_if.en, s_if.up, s_if.down, s_if.load, int'(s_if.load_val));
        mmn = step(mmn, 0, 59, rst_c, sec_carry_old, 1'b1, 1'b0, m_if.load, int'(m_if.load_val));
    end

    task automatic cmp_inst(input string nm, input ms_t m, input logic [7:0] c, input logic [7:0] b,
                            input logic ca, input logic bo, input logic cf, input logic le);
        check({nm, ".cnt"},      32'(c),  32'(m.cnt));
        check({nm, ".cnt_bcd"},  32'(b),  32'(m.bcd));
        check({nm, ".carry"},    32'(ca), 32'(m.carry));
        check({nm, ".borrow"},   32'(bo), 32'(m.borrow));
        check({nm, ".conflict"}, 32'(cf), 32'(m.conflict));
        check({nm, ".load_err"}, 32'(le), 32'(m.load_err));
    endtask

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            cmp_inst("hr",  mh,  h_if.cnt, h_if.cnt_bcd, h_if.carry, h_if.borrow, h_if.conflict, h_if.load_err);
            cmp_inst("day", md,  d_if.cnt, d_if.cnt_bcd, d_if.carry, d_if.borrow, d_if.conflict, d_if.load_err);
            cmp_inst("sec", msc, s_if.cnt, s_if.cnt_bcd, s_if.carry, s_if.borrow, s_if.conflict, s_if.load_err);
            cmp_inst("min", mmn, m_if.cnt, m_if.cnt_bcd, m_if.carry, m_if.borrow, m_if.conflict, m_if.load_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic hset(input bit en, input bit up, input bit dn, input bit ld, input int lv);
        h_if.en = en; h_if.up = up; h_if.down = dn; h_if.load = ld; h_if.load_val = 8'(lv);
    endtask

    task automatic dset(input bit en, input bit up, input bit dn, input bit ld, input int lv);
        d_if.en = en; d_if.up = up; d_if.down = dn; d_if.load = ld; d_if.load_val = 8'(lv);
    endtask

    initial begin
        hset(0, 0, 0, 0, 0);
        dset(0, 0, 0, 0, 0);
        s_if.en = 0; s_if.up = 0; s_if.down = 0; s_if.load = 0; s_if.load_val = 0;
        m_if.load = 0; m_if.load_val = 0;
        cyc(); cyc();
        rst_h = 0; rst_d = 0; rst_c = 0;
        chk_on = 1;
        $display("reset released");
        check("hr_rst_cnt", 32'(h_if.cnt), 0);
        check("hr_rst_bcd", 32'(h_if.cnt_bcd), 32'h00);
        check("hr_rst_carry", 32'(h_if.carry), 0);
        check("day_rst_cnt", 32'(d_if.cnt), 1);
        check("day_rst_bcd", 32'(d_if.cnt_bcd), 32'h01);

        // Count up the hours counter through its full range and wrap.
        hset(1, 1, 0, 0, 0);
        repeat (23) cyc();
        $display("hr up x23 cnt=%0d", h_if.cnt);
        check("hr_up23_cnt", 32'(h_if.cnt), 23);
        check("hr_up23_bcd_lag", 32'(h_if.cnt_bcd), 32'h22);
        cyc();
        $display("hr wrap cnt=%0d carry=%0d", h_if.cnt, h_if.carry);
        check("hr_wrap_cnt", 32'(h_if.cnt), 0);
        check("hr_wrap_carry", 32'(h_if.carry), 1);
        check("hr_wrap_bcd", 32'(h_if.cnt_bcd), 32'h23);
        hset(0, 0, 0, 0, 0);
        cyc();
        check("hr_carry_once", 32'(h_if.carry), 0);

        // Count down from MIN and wrap to MAX.
        hset(1, 0, 1, 0, 0);
        cyc();
        $display("hr down wrap cnt=%0d borrow=%0d", h_if.cnt, h_if.borrow);
        check("hr_borrow_cnt", 32'(h_if.cnt), 23);
        check("hr_borrow", 32'(h_if.borrow), 1);
        cyc();
        check("hr_down22_cnt", 32'(h_if.cnt), 22);
        check("hr_down22_borrow", 32'(h_if.borrow), 0);

        // Up and down together raise conflict; no count change while disabled.
        hset(0, 0, 0, 1, 5);
        cyc();
        hset(1, 1, 1, 0, 0);
        cyc();
        $display("hr conflict cnt=%0d conflict=%0d", h_if.cnt, h_if.conflict);
        check("hr_conflict_cnt", 32'(h_if.cnt), 5);
        check("hr_conflict", 32'(h_if.conflict), 1);
        hset(0, 1, 0, 0, 0);
        repeat (10) cyc();
        check("hr_disabled_cnt", 32'(h_if.cnt), 5);
        check("hr_disabled_flags", 32'({h_if.carry, h_if.borrow, h_if.conflict}), 0);

        // Load in range, load out of range, and load overriding a count at MAX.
        hset(0, 0, 0, 1, 17);
        cyc();
        hset(0, 0, 0, 0, 0);
        check("hr_load17_cnt", 32'(h_if.cnt), 17);
        cyc();
        $display("hr load 17 bcd=%h", h_if.cnt_bcd);
        check("hr_load17_bcd", 32'(h_if.cnt_bcd), 32'h17);
        hset(0, 0, 0, 1, 30);
        cyc();
        $display("hr load 30 cnt=%0d load_err=%0d", h_if.cnt, h_if.load_err);
        check("hr_load30_cnt", 32'(h_if.cnt), 17);
        check("hr_load30_err", 32'(h_if.load_err), 1);
        hset(0, 0, 0, 1, 23);
        cyc();
        check("hr_load_err_once", 32'(h_if.load_err), 0);
        hset(1, 1, 0, 1, 2);
        cyc();
        $display("hr load over count cnt=%0d carry=%0d", h_if.cnt, h_if.carry);
        check("hr_loadprio_cnt", 32'(h_if.cnt), 2);
        check("hr_loadprio_carry", 32'(h_if.carry), 0);
        hset(0, 0, 0, 0, 0);

        // Day-of-month counter, range 1-31.
        dset(0, 0, 0, 1, 31);
        cyc();
        dset(1, 1, 0, 0, 0);
        cyc();
        $display("day up wrap cnt=%0d carry=%0d", d_if.cnt, d_if.carry);
        check("day_wrap_cnt", 32'(d_if.cnt), 1);
        check("day_wrap_carry", 32'(d_if.carry), 1);
        dset(1, 0, 1, 0, 0);
        cyc();
        $display("day down wrap cnt=%0d borrow=%0d", d_if.cnt, d_if.borrow);
        check("day_borrow_cnt", 32'(d_if.cnt), 31);
        check("day_borrow", 32'(d_if.borrow), 1);
        dset(0, 0, 0, 1, 0);
        cyc();
        $display("day load 0 cnt=%0d load_err=%0d", d_if.cnt, d_if.load_err);
        check("day_load0_err", 32'(d_if.load_err), 1);
        check("day_load0_cnt", 32'(d_if.cnt), 31);
        dset(0, 0, 0, 1, 1);
        cyc();
        check("day_load1_cnt", 32'(d_if.cnt), 1);
        check("day_load1_err", 32'(d_if.load_err), 0);
        dset(0, 0, 0, 0, 0);

        // Seconds cascade into minutes from 59:59.
        s_if.load = 1; s_if.load_val = 8'd59; m_if.load = 1; m_if.load_val = 8'd59;
        cyc();
        s_if.load = 0; m_if.load = 0;
        s_if.en = 1; s_if.up = 1;
        cyc();
        $display("cascade tick sec=%0d carry=%0d min=%0d", s_if.cnt, s_if.carry, m_if.cnt);
        check("casc_sec_cnt", 32'(s_if.cnt), 0);
        check("casc_sec_carry", 32'(s_if.carry), 1);
        check("casc_min_wait", 32'(m_if.cnt), 59);
        s_if.en = 0; s_if.up = 0;
        cyc();
        $display("cascade follow min=%0d carry=%0d", m_if.cnt, m_if.carry);
        check("casc_min_cnt", 32'(m_if.cnt), 0);
        check("casc_min_carry", 32'(m_if.carry), 1);

        // Reset during the seconds carry must suppress the minutes increment.
        s_if.load = 1; s_if.load_val = 8'd59; m_if.load = 1; m_if.load_val = 8'd10;
        cyc();
        s_if.load = 0; m_if.load = 0;
        s_if.en = 1; s_if.up = 1;
        cyc();
        check("rstc_carry_seen", 32'(s_if.carry), 1);
        s_if.en = 0; s_if.up = 0;
        rst_c = 1;
        cyc();
        rst_c = 0;
        $display("cascade reset sec=%0d min=%0d", s_if.cnt, m_if.cnt);
        check("rstc_sec_cnt", 32'(s_if.cnt), 0);
        check("rstc_min_cnt", 32'(m_if.cnt), 0);
        check("rstc_sec_carry", 32'(s_if.carry), 0);
        cyc();
        check("rstc_min_hold", 32'(m_if.cnt), 0);
        check("rstc_min_bcd", 32'(m_if.cnt_bcd), 32'h00);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
